// File: rtl/rect_pos_sched.sv
// Purpose : frame-synchronous scheduler for the rectangle position bus (mouse vs. animation).
// Latency : commits take effect on the cycle after the vblnk rising edge (fe); anim_start pulses one cycle after handover.
// Backpres: single-entry pending buffer; anim_ready drops while it is full and returns after the committing fe.
//
// Ports:
//   pclk, rst                 pixel clock, synchronous active-high reset
//   vblnk                     vertical blanking level; its rising edge is the only commit point
//   mouse_left/xpos/ypos      live mouse button and position
//   anim_valid/xpos/ypos      animation sample offer; anim_ready accepts it
//   anim_start                one-cycle restart pulse for the animation engine
//   xpos, ypos, owner         committed rectangle position and current owner (1 = animation)
module rect_pos_sched #(
   parameter int X_MAX        = 799,
   parameter int Y_MAX        = 599,
   parameter int STALL_FRAMES = 4
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        mouse_left,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        anim_valid,
   input  logic [11:0] anim_xpos,
   input  logic [11:0] anim_ypos,
   output logic        anim_ready,
   output logic        anim_start,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        owner
);

   localparam logic [1:0] ST_MOUSE = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_ANIM  = 2'd2;

   localparam logic [11:0] X_LIM     = 12'(X_MAX);
   localparam logic [11:0] Y_LIM     = 12'(Y_MAX);
   localparam logic [3:0]  STALL_LIM = 4'(STALL_FRAMES);

   function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] m);
      return (v > m) ? m : v;
   endfunction

   logic [1:0]  state_q, state_d;
   logic        vblnk_d_q, vblnk_d_d;
   logic        fe_en_q, fe_en_d;
   logic [11:0] xpos_q, xpos_d;
   logic [11:0] ypos_q, ypos_d;
   logic [11:0] pend_x_q, pend_x_d;
   logic [11:0] pend_y_q, pend_y_d;
   logic        pend_full_q, pend_full_d;
   logic [3:0]  stall_q, stall_d;
   logic        anim_start_q, anim_start_d;
   logic        owner_q, owner_d;

   logic        fe;
   logic        accept;
   logic [3:0]  stall_inc;

   // fe_en blocks the spurious edge that vblnk_d's reset value would create
   // if vblnk is already high when reset releases: an edge counts only
   // after vblnk has been seen low at least once since reset.
   assign fe         = vblnk & ~vblnk_d_q & fe_en_q;
   assign anim_ready = (state_q == ST_ANIM) & ~pend_full_q;
   assign accept     = anim_valid & anim_ready;

   always_comb begin
      state_d     = state_q;
      vblnk_d_d   = vblnk;
      fe_en_d     = fe_en_q | ~vblnk;
      xpos_d      = xpos_q;
      ypos_d      = ypos_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      pend_full_d = pend_full_q;
      stall_d     = stall_q;
      stall_inc   = stall_q + 4'd1;

      // A handshake on an fe cycle only happens with the buffer empty, so
      // it never collides with a commit of the same entry.
      if (accept) begin
         pend_x_d    = anim_xpos;
         pend_y_d    = anim_ypos;
         pend_full_d = 1'b1;
      end

      case (state_q)
         ST_MOUSE: begin
            if (fe) begin
               xpos_d = clamp(mouse_xpos, X_LIM);
               ypos_d = clamp(mouse_ypos, Y_LIM);
               if (mouse_left) state_d = ST_ARM;
            end
         end
         ST_ARM: begin
            pend_full_d = 1'b0;
            stall_d     = 4'd0;
            state_d     = ST_ANIM;
         end
         ST_ANIM: begin
            if (fe) begin
               if (!mouse_left) begin
                  xpos_d      = clamp(mouse_xpos, X_LIM);
                  ypos_d      = clamp(mouse_ypos, Y_LIM);
                  pend_full_d = 1'b0;
                  state_d     = ST_MOUSE;
               end else if (pend_full_q) begin
                  xpos_d      = clamp(pend_x_q, X_LIM);
                  ypos_d      = clamp(pend_y_q, Y_LIM);
                  pend_full_d = 1'b0;
                  stall_d     = 4'd0;
               end else if (stall_inc == STALL_LIM) begin
                  // Engine went quiet for too long: restart it.
                  stall_d = 4'd0;
                  state_d = ST_ARM;
               end else begin
                  stall_d = stall_inc;
               end
            end
         end
         default: state_d = ST_MOUSE;
      endcase

      // Registered decodes of the next state keep these outputs glitch-free.
      anim_start_d = (state_d == ST_ARM);
      owner_d      = (state_d != ST_MOUSE);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= ST_MOUSE;
         vblnk_d_q    <= 1'b0;
         fe_en_q      <= 1'b0;
         xpos_q       <= 12'd0;
         ypos_q       <= 12'd0;
         pend_x_q     <= 12'd0;
         pend_y_q     <= 12'd0;
         pend_full_q  <= 1'b0;
         stall_q      <= 4'd0;
         anim_start_q <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         vblnk_d_q    <= vblnk_d_d;
         fe_en_q      <= fe_en_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         pend_x_q     <= pend_x_d;
         pend_y_q     <= pend_y_d;
         pend_full_q  <= pend_full_d;
         stall_q      <= stall_d;
         anim_start_q <= anim_start_d;
         owner_q      <= owner_d;
      end
   end

   assign xpos       = xpos_q;
   assign ypos       = ypos_q;
   assign anim_start = anim_start_q;
   assign owner      = owner_q;

endmodule

// File: tb/tb_rect_pos_sched.sv
// Purpose : directed self-checking bench for rect_pos_sched.
// Latency : inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpres: the bench plays the animation engine, holding anim_valid until anim_ready accepts it.
module tb_rect_pos_sched;

   logic        pclk = 1'b0;
   logic        rst;
   logic        vblnk;
   logic        mouse_left;
   logic [11:0] mouse_xpos, mouse_ypos;
   logic        anim_valid;
   logic [11:0] anim_xpos, anim_ypos;
   logic        anim_ready, anim_start, owner;
   logic [11:0] xpos, ypos;

   int errors = 0;
   int checks = 0;

   rect_pos_sched #(.X_MAX(799), .Y_MAX(599), .STALL_FRAMES(4)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .vblnk      (vblnk),
      .mouse_left (mouse_left),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .anim_valid (anim_valid),
      .anim_xpos  (anim_xpos),
      .anim_ypos  (anim_ypos),
      .anim_ready (anim_ready),
      .anim_start (anim_start),
      .xpos       (xpos),
      .ypos       (ypos),
      .owner      (owner)
   );

   always #5 pclk = ~pclk;

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pos(input string tag, input int ex, input int ey);
      chk({tag, ".x"}, 32'(xpos), 32'(ex));
      chk({tag, ".y"}, 32'(ypos), 32'(ey));
   endtask

   task automatic chk_ctl(input string tag, input int e_start, input int e_owner, input int e_ready);
      chk({tag, ".anim_start"}, 32'(anim_start), 32'(e_start));
      chk({tag, ".owner"},      32'(owner),      32'(e_owner));
      chk({tag, ".anim_ready"}, 32'(anim_ready), 32'(e_ready));
   endtask

   // Raise vblnk and let the fe edge occur; outputs then show the commit.
   task automatic vb_rise();
      vblnk = 1'b1;
      tick();
   endtask

   task automatic vb_fall();
      vblnk = 1'b0;
      tick();
      tick();
   endtask

   task automatic offer(input int x, input int y);
      anim_valid = 1'b1;
      anim_xpos  = 12'(x);
      anim_ypos  = 12'(y);
   endtask

   initial begin
      rst = 1'b1; vblnk = 1'b0; mouse_left = 1'b0;
      mouse_xpos = 12'd0; mouse_ypos = 12'd0;
      anim_valid = 1'b0; anim_xpos = 12'd0; anim_ypos = 12'd0;
      repeat (3) tick();
      chk_pos("reset", 0, 0);
      chk_ctl("reset", 0, 0, 0);

      // Pass-through: nothing commits before the first fe.
      rst = 1'b0; mouse_xpos = 12'd100; mouse_ypos = 12'd200;
      tick(); tick();
      chk_pos("pre_fe", 0, 0);
      vb_rise();
      chk_pos("pass", 100, 200);
      tick();
      chk_pos("pass_hold", 100, 200);
      vb_fall();

      // Clamp at both axes.
      mouse_xpos = 12'd900; mouse_ypos = 12'd650;
      vb_rise();
      chk_pos("clamp", 799, 599);
      vb_fall();

      // Handover: mouse commit on the fe, then ARM, then ANIM.
      mouse_xpos = 12'd5; mouse_ypos = 12'd5; mouse_left = 1'b1;
      vb_rise();
      chk_pos("handover_fe", 5, 5);
      chk_ctl("arm", 1, 1, 0);
      tick();
      chk_ctl("anim", 0, 1, 1);
      vblnk = 1'b0;
      offer(376, 120);
      tick();
      chk("accept1.ready", 32'(anim_ready), 0);
      anim_valid = 1'b0;
      tick();
      chk_pos("no_commit_midframe", 5, 5);
      vb_rise();
      chk_pos("anim_commit", 376, 120);
      chk("after_commit.ready", 32'(anim_ready), 1);
      vb_fall();

      // Backpressure: second sample waits until the first is committed.
      offer(10, 10);
      tick();
      chk("bp_first.ready", 32'(anim_ready), 0);
      offer(11, 12);
      tick(); tick();
      chk("bp_hold.ready", 32'(anim_ready), 0);
      chk_pos("bp_hold", 376, 120);
      vb_rise();
      chk_pos("bp_commit1", 10, 10);
      chk("bp_reopen.ready", 32'(anim_ready), 1);
      tick();
      chk("bp_second.ready", 32'(anim_ready), 0);
      anim_valid = 1'b0;
      vblnk = 1'b0;
      tick();
      vb_rise();
      chk_pos("bp_commit2", 11, 12);

      // Stall re-arm after four empty frames.
      for (int f = 1; f <= 3; f++) begin
         vb_fall();
         vb_rise();
         chk("stall_quiet.anim_start", 32'(anim_start), 0);
      end
      chk_pos("stall_quiet", 11, 12);
      vb_fall();
      vb_rise();
      chk_ctl("stall_rearm", 1, 1, 0);
      chk_pos("stall_rearm", 11, 12);
      tick();
      chk_ctl("stall_anim", 0, 1, 1);

      // Release with a sample pending: mouse wins, pending dropped.
      vblnk = 1'b0;
      offer(77, 88);
      tick();
      anim_valid = 1'b0;
      mouse_left = 1'b0; mouse_xpos = 12'd50; mouse_ypos = 12'd60;
      tick();
      vb_rise();
      chk_pos("release", 50, 60);
      chk_ctl("release", 0, 0, 0);
      mouse_left = 1'b1;
      vb_fall();
      vb_rise();
      tick();
      chk_ctl("reown", 0, 1, 1);
      vb_fall();
      vb_rise();
      chk_pos("pend_dropped", 50, 60);

      // Mid-frame reset while a sample is pending.
      vblnk = 1'b0;
      offer(300, 300);
      tick();
      anim_valid = 1'b0;
      chk("pre_rst.ready", 32'(anim_ready), 0);
      rst = 1'b1;
      tick();
      chk_pos("mid_rst", 0, 0);
      chk_ctl("mid_rst", 0, 0, 0);

      // vblnk already high at reset release must not produce an fe.
      vblnk = 1'b1; mouse_left = 1'b0; mouse_xpos = 12'd123; mouse_ypos = 12'd45;
      tick();
      rst = 1'b0;
      repeat (3) tick();
      chk_pos("rst_vblnk_high", 0, 0);
      vblnk = 1'b0;
      tick();
      vb_rise();
      chk_pos("post_rst_fe", 123, 45);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rect_pos_sched.md
# rect_pos_sched

Frame-synchronous scheduler for the rectangle position bus that feeds the rectangle drawing stage. It arbitrates between the live mouse position and the bouncing-trajectory animation engine, hands ownership to the animation while the left button is held, and commits new coordinates only at the start of vertical blanking so the rectangle never tears mid-frame. It also re-arms a stalled animation engine after a programmable number of frames with no data.

## Interface
- X_MAX, 799: largest legal x coordinate; larger values clamp to X_MAX.
- Y_MAX, 599: largest legal y coordinate; larger values clamp to Y_MAX.
- STALL_FRAMES, 4: consecutive committed frames in ANIM with no new sample before the engine is re-armed; legal range 1..15.
- pclk  in  1  pixel clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- vblnk  in  1  vertical blanking level from the timing generator.
- mouse_left  in  1  left-button level; 1 requests animation ownership.
- mouse_xpos  in  12  live mouse x.
- mouse_ypos  in  12  live mouse y.
- anim_valid  in  1  animation sample valid.
- anim_xpos  in  12  animation sample x.
- anim_ypos  in  12  animation sample y.
- anim_ready  out  1  scheduler can accept an animation sample.
- anim_start  out  1  one-cycle pulse that restarts the animation engine from its origin.
- xpos  out  12  committed rectangle x.
- ypos  out  12  committed rectangle y.
- owner  out  1  0 = mouse owns the position, 1 = animation owns it.

## Operation
- Frame edge: vblnk_d is vblnk registered. fe = vblnk & ~vblnk_d. All commits happen only in cycles where fe = 1.
- Clamp: clamp(v, M) = M if v > M, else v. Compare unsigned at 12 bits. Every value written to xpos or ypos is clamped.
- Pending buffer: one entry (pend_x, pend_y, pend_full). It accepts a sample when anim_valid & anim_ready.
- anim_ready = (state == ANIM) & ~pend_full.
- States:
  - MOUSE (the reset state):
    - On fe: xpos/ypos <= clamped mouse position.
    - If mouse_left = 1 at fe, go to ARM.
  - ARM:
    - Lasts exactly one cycle with anim_start = 1.
    - Clears pend_full and the stall counter.
    - Goes to ANIM. xpos/ypos are held.
  - ANIM (owner = 1):
    - On fe with mouse_left = 0: commit the clamped mouse position, clear pend_full, go to MOUSE.
    - On fe with mouse_left = 1 and pend_full = 1: commit clamped pend_x/pend_y, clear pend_full, clear the stall counter.
    - On fe with mouse_left = 1 and pend_full = 0: hold xpos/ypos and increment the 4-bit stall counter. If the incremented value equals STALL_FRAMES, go to ARM and clear the counter.
- owner = 1 in ARM and ANIM, 0 in MOUSE.
- Simultaneous accept and fe:
  - A commit reads the pending contents registered before the edge.
  - Because anim_ready = 0 whenever pend_full = 1, an accept and a commit of the same entry cannot coincide.
  - If fe arrives while pend_full = 0 and a handshake also occurs, the sample is stored and committed on the next fe. The stall counter still increments for this frame.
- mouse_left changing between edges has no effect; it is sampled only at fe.
- An anim_valid held while anim_ready = 0 is not consumed. The engine must hold the sample until it is accepted.

## Timing
- Reset (all synchronous):
  - state = MOUSE.
  - xpos = 0, ypos = 0.
  - owner = 0, anim_ready = 0, anim_start = 0.
  - pend_full = 0, stall counter = 0, vblnk_d = 0.
- Reset asserted mid-operation:
  - Returns to these values on the next pclk edge.
  - Any pending sample is discarded and no anim_start is issued.
  - If vblnk is already high when reset is released, no fe occurs until vblnk goes low and rises again.
- Commit latency: vblnk first sampled high in cycle N gives fe in cycle N. The new xpos/ypos are visible from cycle N+1.
- Ownership handover:
  - fe in cycle N with mouse_left = 1 in MOUSE: state = ARM in N+1 (anim_start = 1, owner = 1), ANIM in N+2, anim_ready = 1 from N+2.
  - The first animation commit is at the next fe.
- Handshake: a sample accepted in cycle K gives pend_full = 1 and anim_ready = 0 from K+1. anim_ready returns to 1 the cycle after the committing fe.
- All outputs are registered except anim_ready, which is decoded from registered state.

## Test plan
- Reset and pass-through:
  - Stimulus: mouse at (100, 200), vblnk pulses.
  - Required: xpos/ypos = 0 until the first fe, then (100, 200) one cycle after vblnk rises.
- Clamp:
  - Stimulus: mouse at (900, 650) at fe.
  - Required: xpos = 799, ypos = 599.
- Handover:
  - Stimulus: mouse_left = 1 at fe; engine then supplies (376, 120).
  - Required: one anim_start pulse 1 cycle after fe, owner = 1, anim_ready from 2 cycles after fe, and (376, 120) committed at the next fe.
- Backpressure:
  - Stimulus: two consecutive samples (10, 10) and (11, 12) offered within one frame.
  - Required: first accepted, anim_ready = 0, second held until after the next fe; commits are (10, 10) then (11, 12) on successive frames.
- Stall re-arm:
  - Stimulus: mouse_left held, engine silent, STALL_FRAMES = 4.
  - Required: after the 4th empty fe, state = ARM and a second anim_start pulse; xpos/ypos unchanged.
- Release and mid-frame reset:
  - Stimulus: mouse_left dropped, mouse at (50, 60), at a fe with a sample pending.
  - Required: (50, 60) committed, pending dropped, owner = 0.
  - Stimulus: rst asserted while in ANIM.
  - Required: all outputs return to their reset values on the next cycle.
